avalon_master: RTL and testbench
================================

AVALON_MASTER -- requirements
Module: avalon_master

Interface
REQ-001 Parameter: TIMEOUT, default 16, cycles allowed per bus transfer before abort with error (legal 2..255).
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 CMD_VALID  input  1  user command present.
REQ-005 CMD_READY  output  1  block accepts a command this cycle.
REQ-006 CMD_WRITE  input  1  1 = write, 0 = read.
REQ-007 CMD_ADDRESS  input  32  byte address.
REQ-008 CMD_WRITEDATA  input  32  write data.
REQ-009 CMD_BYTE_ENABLE  input  4  byte lanes.
REQ-010 RSP_VALID  output  1  one-cycle response pulse; no backpressure.
REQ-011 RSP_READDATA  output  32  read data, valid with RSP_VALID on reads, else 0.
REQ-012 RSP_ERROR  output  1  1 = timeout or illegal command.
REQ-013 ADDRESS, WRITEDATA  output  32 each  Avalon-MM address/write data.
REQ-014 BYTE_ENABLE  output  4; READ, WRITE, BEGINTRANSFER, LOCK, BEGINBURSTTRANSFER  output  1 each; BURSTCOUNT  output  3.
REQ-015 READDATA  input  32; WAITREQUEST, READDATAVALID  input  1 each.

Function
REQ-016 States: IDLE, XFER (READ/WRITE asserted), RD_WAIT (read accepted, awaiting READDATAVALID), RESP (RSP_VALID pulse).
REQ-017 CMD_READY = 1 only in IDLE; command accepted on CMD_VALID & CMD_READY; address, data, byte enables, direction registered at acceptance.
REQ-018 Illegal command (CMD_ADDRESS[1:0] != 0, or CMD_BYTE_ENABLE = 0): no bus activity; IDLE -> RESP with RSP_ERROR = 1, RSP_READDATA = 0.
REQ-019 Legal command accepted in cycle N: READ or WRITE = 1 from cycle N+1 in XFER; BEGINTRANSFER = 1 only in cycle N+1.
REQ-020 ADDRESS, WRITEDATA, BYTE_ENABLE held stable throughout XFER, driven from registers, 0 outside XFER.
REQ-021 XFER exits on first cycle with WAITREQUEST = 0; READ/WRITE deassert next cycle.
REQ-022 Write: exit XFER -> RESP; RSP_VALID one cycle later, RSP_ERROR = 0.
REQ-023 Read: READDATAVALID sampled in XFER on the accepting cycle (zero-latency slave) and in every RD_WAIT cycle; if seen in the accepting cycle -> RESP directly, else -> RD_WAIT.
REQ-024 READDATA captured on the READDATAVALID cycle; RSP_VALID and RSP_READDATA appear the following cycle.
REQ-025 READDATAVALID outside XFER/RD_WAIT ignored; no capture, no response.
REQ-026 Timeout counter cleared at command acceptance, increments each cycle in XFER or RD_WAIT; reaching TIMEOUT without completion -> READ/WRITE drop, RESP with RSP_ERROR = 1, RSP_READDATA = 0.
REQ-027 Completion and timeout in same cycle: completion wins, RSP_ERROR = 0.
REQ-028 RESP lasts exactly one cycle, then IDLE; a new command is acceptable the cycle after RESP, so back-to-back transfers have a one-idle-cycle minimum gap.
REQ-029 LOCK = 0, BEGINBURSTTRANSFER = 0, BURSTCOUNT = 3'd1 constantly (single transfers only).
REQ-030 At most one transaction outstanding at any time.

Reset
REQ-031 RESET_N low asynchronously forces IDLE, counter 0, all registers 0; outputs: CMD_READY = 0 while reset is asserted, READ = WRITE = BEGINTRANSFER = RSP_VALID = RSP_ERROR = 0, all buses 0, BURSTCOUNT = 1.
REQ-032 Reset mid-transaction aborts it silently: no RSP_VALID for that command; first acceptance possible on first rising edge after RESET_N deasserts.

Structure
REQ-033 Shared package avalon_master_pkg holds the state enumeration, BURSTCOUNT_SINGLE = 3'd1, and the Avalon data/address width constants (32).
REQ-034 One sub-module, avalon_master_timeout: clear/enable-driven counter with expired flag, width sized for TIMEOUT.

Verification
REQ-035 Write 0x0000_0004, data 0xDEAD_BEEF, BE 1111, WAITREQUEST low -> WRITE high exactly 1 cycle with BEGINTRANSFER, RSP_VALID 1 cycle later, RSP_ERROR = 0.
REQ-036 Read 0x0000_0008, slave returns 0x1234_5678 with READDATAVALID in the accepting cycle -> RSP_READDATA = 0x1234_5678 next cycle, no RD_WAIT.
REQ-037 Read with WAITREQUEST high 3 cycles, READDATAVALID 2 cycles after acceptance -> READ high 4 cycles, ADDRESS stable, BEGINTRANSFER only first cycle, correct data returned.
REQ-038 Read with READDATAVALID never asserted, TIMEOUT = 16 -> RSP_VALID with RSP_ERROR = 1, RSP_READDATA = 0 after 16 bus cycles; next command accepted normally.
REQ-039 Command address 0x0000_0006 or BE 0000 -> no READ/WRITE, RSP_ERROR = 1 next cycle.
REQ-040 RESET_N pulsed low mid-XFER -> READ drops immediately without clock, no RSP_VALID, CMD_READY = 1 after release.

Source files
------------

// File: rtl/avalon_master_pkg.sv
// -----------------------------------------------------------------------------
// avalon_master_pkg
// Shared definitions for the single-transfer Avalon-MM master:
//   - bus width constants (address / data / byte-enable / burstcount)
//   - controller state enumeration
//   - command legality helper used at command acceptance
// -----------------------------------------------------------------------------
package avalon_master_pkg;

    localparam int AVM_ADDR_W  = 32;
    localparam int AVM_DATA_W  = 32;
    localparam int AVM_BE_W    = AVM_DATA_W / 8;
    localparam int AVM_BURST_W = 3;

    // Only single-beat transfers are ever issued.
    localparam logic [AVM_BURST_W-1:0] BURSTCOUNT_SINGLE = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a user command
        ST_XFER    = 2'd1,  // READ/WRITE asserted on the bus
        ST_RD_WAIT = 2'd2,  // read accepted, waiting for READDATAVALID
        ST_RESP    = 2'd3   // one-cycle response pulse
    } state_e;

    // A command is legal when it is word aligned and enables at least one lane.
    function automatic logic cmd_is_legal(input logic [AVM_ADDR_W-1:0] addr,
                                          input logic [AVM_BE_W-1:0]   be);
        return (addr[1:0] == 2'b00) && (be != '0);
    endfunction

endpackage

// File: rtl/avalon_master_if.sv
// -----------------------------------------------------------------------------
// avalon_master_if
// Bundles the user command/response handshake and the Avalon-MM bus.
//   master modport : the avalon_master block (drives cmd_ready, rsp_*, bus ctrl)
//   slave  modport : the environment (user command source + Avalon slave)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_writedata/cmd_byte_enable
//   rsp_valid/rsp_readdata/rsp_error
//   address/writedata/byte_enable/read/write/begintransfer/lock/
//   beginbursttransfer/burstcount (to slave)
//   readdata/waitrequest/readdatavalid (from slave)
// -----------------------------------------------------------------------------
interface avalon_master_if;
    import avalon_master_pkg::*;

    // user command side
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [AVM_ADDR_W-1:0]  cmd_address;
    logic [AVM_DATA_W-1:0]  cmd_writedata;
    logic [AVM_BE_W-1:0]    cmd_byte_enable;

    // user response side
    logic                   rsp_valid;
    logic [AVM_DATA_W-1:0]  rsp_readdata;
    logic                   rsp_error;

    // Avalon-MM bus
    logic [AVM_ADDR_W-1:0]  address;
    logic [AVM_DATA_W-1:0]  writedata;
    logic [AVM_BE_W-1:0]    byte_enable;
    logic                   read;
    logic                   write;
    logic                   begintransfer;
    logic                   lock;
    logic                   beginbursttransfer;
    logic [AVM_BURST_W-1:0] burstcount;
    logic [AVM_DATA_W-1:0]  readdata;
    logic                   waitrequest;
    logic                   readdatavalid;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byte_enable,
        output cmd_ready,
        output rsp_valid, rsp_readdata, rsp_error,
        output address, writedata, byte_enable, read, write, begintransfer,
        output lock, beginbursttransfer, burstcount,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byte_enable,
        input  cmd_ready,
        input  rsp_valid, rsp_readdata, rsp_error,
        input  address, writedata, byte_enable, read, write, begintransfer,
        input  lock, beginbursttransfer, burstcount,
        output readdata, waitrequest, readdatavalid
    );

endinterface

// File: rtl/avalon_master_timeout.sv
// -----------------------------------------------------------------------------
// avalon_master_timeout
// Per-transfer cycle counter.
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : restart counting from zero (priority over enable)
//   i_enable   : count this cycle
//   o_expired  : the current cycle is the TIMEOUT-th counted cycle (or later)
// The counter saturates at TIMEOUT-1, so it never wraps back to "not expired".
// -----------------------------------------------------------------------------
module avalon_master_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count value k means k bus cycles have already elapsed, so k == TIMEOUT-1
    // marks the last allowed cycle.
    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/avalon_master.sv
// -----------------------------------------------------------------------------
// avalon_master
// Turns single user commands into single Avalon-MM read/write transfers with a
// per-transfer timeout, and returns a one-cycle response pulse.
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : avalon_master_if.master (command, response and Avalon-MM bus)
// Parameter TIMEOUT: cycles allowed in XFER+RD_WAIT before abort (2..255).
// -----------------------------------------------------------------------------
module avalon_master
    import avalon_master_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    avalon_master_if.master bus
);

    state_e                r_state;
    state_e                w_state_next;

    logic [AVM_ADDR_W-1:0] r_addr;
    logic [AVM_DATA_W-1:0] r_wdata;
    logic [AVM_BE_W-1:0]   r_be;
    logic                  r_write;
    logic                  r_first;   // first XFER cycle -> BEGINTRANSFER
    logic                  r_error;
    logic [AVM_DATA_W-1:0] r_rdata;

    logic                  w_cmd_ready;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_abort;
    logic                  w_count_en;
    logic                  w_expired;
    logic                  w_in_xfer;
    logic                  w_in_resp;

    assign w_legal = cmd_is_legal(bus.cmd_address, bus.cmd_byte_enable);

    // ---------------------------------------------------------------- timeout
    avalon_master_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_accept),
        .i_enable  (w_count_en),
        .o_expired (w_expired)
    );

    // ------------------------------------------------------------ state reg
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------ next state / controls
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_in_xfer    = (r_state == ST_XFER);
        w_in_resp    = (r_state == ST_RESP);
        w_count_en   = (r_state == ST_XFER) || (r_state == ST_RD_WAIT);
        // Reset forces IDLE, but the block must not look ready while held.
        w_cmd_ready  = (r_state == ST_IDLE) && i_rst_n;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && w_cmd_ready) begin
                    w_accept     = 1'b1;
                    // Illegal commands never touch the bus.
                    w_state_next = w_legal ? ST_XFER : ST_RESP;
                end
            end
            ST_XFER: begin
                // Completion is checked before expiry so it wins a tie.
                if (!bus.waitrequest) begin
                    if (r_write) begin
                        w_state_next = ST_RESP;
                    end else if (bus.readdatavalid) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_RESP;
                    end else if (w_expired) begin
                        w_abort      = 1'b1;
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_RD_WAIT;
                    end
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (bus.readdatavalid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------- datapath regs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
            r_first <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_first <= 1'b0;
            if (w_accept) begin
                r_addr  <= bus.cmd_address;
                r_wdata <= bus.cmd_writedata;
                r_be    <= bus.cmd_byte_enable;
                r_write <= bus.cmd_write;
                r_first <= w_legal;
                r_error <= ~w_legal;
                r_rdata <= '0;
            end else begin
                if (w_capture) begin
                    r_rdata <= bus.readdata;
                end
                if (w_abort) begin
                    r_error <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.cmd_ready          = w_cmd_ready;

    assign bus.read               = w_in_xfer && !r_write;
    assign bus.write              = w_in_xfer &&  r_write;
    assign bus.begintransfer      = w_in_xfer && r_first;
    assign bus.address            = w_in_xfer ? r_addr  : '0;
    assign bus.writedata          = w_in_xfer ? r_wdata : '0;
    assign bus.byte_enable        = w_in_xfer ? r_be    : '0;

    assign bus.lock               = 1'b0;
    assign bus.beginbursttransfer = 1'b0;
    assign bus.burstcount         = BURSTCOUNT_SINGLE;

    // Reads report captured data; writes and errors report zero.
    assign bus.rsp_valid          = w_in_resp;
    assign bus.rsp_error          = w_in_resp && r_error;
    assign bus.rsp_readdata       = (w_in_resp && !r_write && !r_error) ? r_rdata : '0;

endmodule

// File: tb/tb_avalon_master.sv
// -----------------------------------------------------------------------------
// tb_avalon_master
// Table-driven bench: each vector configures a simple Avalon slave model
// (WAITREQUEST length, READDATAVALID delay, read data), issues one command,
// pushes the expected response to a scoreboard queue and compares it with the
// response the monitor records. Hand-written sequences cover reset mid-XFER
// and READDATAVALID outside a transfer.
// -----------------------------------------------------------------------------
module tb_avalon_master;
    import avalon_master_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int NVEC    = 13;
    localparam int NEVER   = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avalon_master_if bus_if ();

    avalon_master #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_n;    // XFER cycles with WAITREQUEST high
        int          rdv_n;     // READDATAVALID delay after accept (NEVER = none)
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;   // cycles from acceptance to RSP_VALID
        int          exp_rw;    // cycles with READ/WRITE high
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          rw;
        logic        wr;
        int          acc_cyc;
        int          b_rd;
        int          b_wr;
        int          b_bt;
        int          b_bad;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t exp_q [$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // slave model configuration / expected bus contents
    int          cfg_wait  = 0;
    int          cfg_rdv   = NEVER;
    logic [31:0] cfg_rdata = '0;
    logic        force_rdv = 1'b0;
    logic [31:0] cur_addr  = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_be    = '0;

    // monitor records (written only by the monitor)
    int          n_rd = 0, n_wr = 0, n_bt = 0, n_bad = 0, idle_bad = 0, const_bad = 0;
    int          rsp_seen = 0;
    logic        obs_err  [64];
    logic [31:0] obs_data [64];
    int          obs_cyc  [64];
    int          obs_rd   [64];
    int          obs_wr   [64];
    int          obs_bt   [64];
    int          obs_bad  [64];
    int          rd_ptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endfunction

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (bus_if.read || bus_if.write) begin
            if (bus_if.read)  n_rd <= n_rd + 1;
            if (bus_if.write) n_wr <= n_wr + 1;
            if (bus_if.begintransfer) n_bt <= n_bt + 1;
            if (bus_if.address !== cur_addr || bus_if.writedata !== cur_wdata ||
                bus_if.byte_enable !== cur_be)
                n_bad <= n_bad + 1;
        end else if (bus_if.address != '0 || bus_if.writedata != '0 ||
                     bus_if.byte_enable != '0 || bus_if.begintransfer) begin
            idle_bad <= idle_bad + 1;
        end
        if (bus_if.lock || bus_if.beginbursttransfer || bus_if.burstcount !== 3'd1)
            const_bad <= const_bad + 1;
        if (!bus_if.rsp_valid && (bus_if.rsp_error || bus_if.rsp_readdata != '0))
            idle_bad <= idle_bad + 1;
        if (bus_if.rsp_valid && rsp_seen < 64) begin
            obs_err[rsp_seen]  <= bus_if.rsp_error;
            obs_data[rsp_seen] <= bus_if.rsp_readdata;
            obs_cyc[rsp_seen]  <= cyc;
            obs_rd[rsp_seen]   <= n_rd;
            obs_wr[rsp_seen]   <= n_wr;
            obs_bt[rsp_seen]   <= n_bt;
            obs_bad[rsp_seen]  <= n_bad;
            rsp_seen           <= rsp_seen + 1;
        end
    end

    // ------------------------------------------------------ slave model
    initial begin
        int xcnt;
        int post;
        bit pending;
        xcnt = 0; post = 0; pending = 0;
        bus_if.waitrequest   = 1'b1;
        bus_if.readdatavalid = 1'b0;
        bus_if.readdata      = '0;
        forever begin
            @(posedge clk); #1;
            bus_if.readdatavalid = 1'b0;
            bus_if.readdata      = '0;
            if (!rst_n) begin
                xcnt = 0; pending = 0; bus_if.waitrequest = 1'b1;
            end else if (bus_if.read || bus_if.write) begin
                if (xcnt == 0) pending = 0;
                bus_if.waitrequest = (xcnt < cfg_wait);
                xcnt++;
                if (!bus_if.waitrequest && bus_if.read) begin
                    if (cfg_rdv == 0) begin
                        bus_if.readdatavalid = 1'b1;
                        bus_if.readdata      = cfg_rdata;
                    end else begin
                        pending = 1; post = 0;
                    end
                end
            end else begin
                xcnt = 0;
                bus_if.waitrequest = 1'b1;
                if (bus_if.rsp_valid) begin
                    pending = 0;
                end else if (pending) begin
                    post++;
                    if (post == cfg_rdv) begin
                        bus_if.readdatavalid = 1'b1;
                        bus_if.readdata      = cfg_rdata;
                        pending = 0;
                    end
                end
            end
            if (force_rdv) begin
                bus_if.readdatavalid = 1'b1;
                bus_if.readdata      = 32'hBAD0_BAD0;
            end
        end
    end

    // ------------------------------------------------- one transaction
    task automatic run_vec(input int id, input vec_t v, input bit expect_rsp);
        exp_t e;
        exp_t g;
        bit   acc;
        cfg_wait  = v.wait_n;
        cfg_rdv   = v.rdv_n;
        cfg_rdata = v.rdata;
        cur_addr  = v.addr;
        cur_wdata = v.wdata;
        cur_be    = v.be;
        @(posedge clk); #1;
        bus_if.cmd_valid       = 1'b1;
        bus_if.cmd_write       = v.wr;
        bus_if.cmd_address     = v.addr;
        bus_if.cmd_writedata   = v.wdata;
        bus_if.cmd_byte_enable = v.be;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (bus_if.cmd_ready) begin
                acc       = 1;
                e.acc_cyc = cyc;
                e.b_rd    = n_rd;
                e.b_wr    = n_wr;
                e.b_bt    = n_bt;
                e.b_bad   = n_bad;
            end
            @(posedge clk); #1;
        end
        bus_if.cmd_valid       = 1'b0;
        bus_if.cmd_write       = 1'b0;
        bus_if.cmd_address     = '0;
        bus_if.cmd_writedata   = '0;
        bus_if.cmd_byte_enable = '0;
        chk($sformatf("v%0d_accepted", id), {31'b0, acc}, 32'd1);
        if (expect_rsp && acc) begin
            e.err  = v.exp_err;
            e.data = v.exp_data;
            e.lat  = v.exp_lat;
            e.rw   = v.exp_rw;
            e.wr   = v.wr;
            exp_q.push_back(e);
            for (int k = 0; k < 60 && rsp_seen == rd_ptr; k++) begin
                @(posedge clk); #2;
            end
            chk($sformatf("v%0d_rsp_arrived", id), {31'b0, rsp_seen > rd_ptr}, 32'd1);
            if (rsp_seen > rd_ptr && exp_q.size() > 0) begin
                g = exp_q.pop_front();
                chk($sformatf("v%0d_rsp_error", id), {31'b0, obs_err[rd_ptr]}, {31'b0, g.err});
                chk($sformatf("v%0d_rsp_readdata", id), obs_data[rd_ptr], g.data);
                chk($sformatf("v%0d_latency", id), obs_cyc[rd_ptr] - g.acc_cyc, g.lat);
                chk($sformatf("v%0d_read_cycles", id), obs_rd[rd_ptr] - g.b_rd, g.wr ? 0 : g.rw);
                chk($sformatf("v%0d_write_cycles", id), obs_wr[rd_ptr] - g.b_wr, g.wr ? g.rw : 0);
                chk($sformatf("v%0d_begintransfer", id), obs_bt[rd_ptr] - g.b_bt, (g.rw > 0) ? 1 : 0);
                chk($sformatf("v%0d_bus_stable", id), obs_bad[rd_ptr] - g.b_bad, 0);
                rd_ptr++;
            end
        end
    endtask

    // ------------------------------------------------------------ main
    initial begin
        vec_t rv;
        int   seen0;
        //           wr    addr          wdata         be    wait  rdv    rdata         err   exp_data     lat rw
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0,    NEVER, 32'h0,        1'b0, 32'h0,        2,  1};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'hF, 0,    0,     32'h1234_5678, 1'b0, 32'h1234_5678, 2, 1};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 3,    2,     32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 7, 4};
        vecs[3]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 0,    NEVER, 32'h0,        1'b1, 32'h0,        17, 1};
        vecs[4]  = '{1'b1, 32'h0000_0006, 32'hAAAA_5555, 4'hF, 0,    NEVER, 32'h0,        1'b1, 32'h0,        1,  0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0,    0,     32'h7777_7777, 1'b1, 32'h0,        1,  0};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'h0102_0304, 4'h3, 15,   NEVER, 32'h0,        1'b0, 32'h0,        17, 16};
        vecs[7]  = '{1'b1, 32'h0000_0104, 32'h0506_0708, 4'hF, NEVER, NEVER, 32'h0,       1'b1, 32'h0,        17, 16};
        vecs[8]  = '{1'b0, 32'h0000_0200, 32'h0,         4'hF, 0,    15,    32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 17, 1};
        vecs[9]  = '{1'b0, 32'h0000_0204, 32'h0,         4'hF, 2,    0,     32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 4, 3};
        vecs[10] = '{1'b1, 32'h0000_0300, 32'h1122_3344, 4'h8, 1,    NEVER, 32'h0,        1'b0, 32'h0,        3,  2};
        vecs[11] = '{1'b0, 32'h0000_0208, 32'h0,         4'hC, 0,    1,     32'h8765_4321, 1'b0, 32'h8765_4321, 3, 1};
        vecs[12] = '{1'b0, 32'h0000_020C, 32'h0,         4'hF, 0,    16,    32'h5555_AAAA, 1'b1, 32'h0,        17, 1};

        bus_if.cmd_valid       = 1'b0;
        bus_if.cmd_write       = 1'b0;
        bus_if.cmd_address     = '0;
        bus_if.cmd_writedata   = '0;
        bus_if.cmd_byte_enable = '0;

        // outputs while reset is held
        #3;
        chk("reset_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd0);
        chk("reset_read_write", {30'b0, bus_if.read, bus_if.write}, 32'd0);
        chk("reset_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
        chk("reset_address", bus_if.address, 32'd0);
        chk("reset_burstcount", {29'b0, bus_if.burstcount}, 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("release_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i], 1'b1);

        // READDATAVALID while idle must be ignored
        @(posedge clk); #2;
        seen0 = rsp_seen;
        force_rdv = 1'b1;
        repeat (4) @(posedge clk);
        #2 force_rdv = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("idle_rdv_no_rsp", rsp_seen - seen0, 32'd0);

        // reset mid-XFER aborts silently
        rv = '{1'b0, 32'h0000_0400, 32'h1111_1111, 4'hF, NEVER, NEVER, 32'h0, 1'b0, 32'h0, 0, 0};
        run_vec(100, rv, 1'b0);
        @(posedge clk); #3;
        chk("pre_reset_read", {31'b0, bus_if.read}, 32'd1);
        seen0 = rsp_seen;
        rst_n = 1'b0;
        #1;
        chk("reset_read_drop", {31'b0, bus_if.read}, 32'd0);
        chk("reset_mid_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd0);
        chk("reset_mid_address", bus_if.address, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1 chk("reset_mid_release_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #2 chk("reset_no_rsp", rsp_seen - seen0, 32'd0);

        // normal traffic afterwards
        run_vec(200, vecs[0], 1'b1);
        run_vec(201, vecs[1], 1'b1);

        repeat (3) @(posedge clk);
        #2;
        chk("no_extra_rsp", rsp_seen - rd_ptr, 32'd0);
        chk("idle_bus_zero", idle_bad, 32'd0);
        chk("const_outputs", const_bad, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
